// File: rtl/drive_74hc165_pkg.sv
// Shared definitions for the 74HC165 chain reader: FSM state encodings and
// the parallel-load pulse length.
package drive_74hc165_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    LOAD  = 4'b0010,
    SHIFT = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  localparam int LOAD_CYC = 4;

endpackage

// File: rtl/drive_74hc165_if.sv
// Bundle of the read handshake, the '165 chain pins and the captured word.
interface drive_74hc165_if #(
  parameter int Width = 16
);

  logic             read_en;
  logic             ser_in;
  logic             sh_ld_n;
  logic             srclk;
  logic             clk_inh;
  logic             busy;
  logic [Width-1:0] data_out;
  logic             data_valid;

  modport master (
    output read_en, ser_in,
    input  sh_ld_n, srclk, clk_inh, busy, data_out, data_valid
  );

  modport slave (
    input  read_en, ser_in,
    output sh_ld_n, srclk, clk_inh, busy, data_out, data_valid
  );

endinterface

// File: rtl/drive_74hc165_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 1 so an
// idle QH line reads as a released key.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/drive_74hc165.sv
// Reads Width bits MSB-first from a 74HC165 chain on request and publishes
// the word with a one-cycle valid strobe.
module drive_74hc165
  import drive_74hc165_pkg::*;
#(
  parameter int Width   = 16,
  parameter int CLK_DIV = 10
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  drive_74hc165_if.slave  bus
);

  localparam int DivW  = $clog2(CLK_DIV);
  localparam int BitW  = $clog2(Width);
  localparam int LoadW = $clog2(LOAD_CYC);

  localparam logic [DivW-1:0]  DivLast   = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0]  DivSample = DivW'(CLK_DIV / 2 - 1);
  localparam logic [BitW-1:0]  BitLast   = BitW'(Width - 1);
  localparam logic [LoadW-1:0] LoadLast  = LoadW'(LOAD_CYC - 1);

  state_t            state;
  logic [LoadW-1:0]  cnt_load;
  logic [DivW-1:0]   cnt_div;
  logic [BitW-1:0]   cnt_bit;
  logic [Width-1:0]  shreg;
  logic              ser_sync;

  logic              sh_ld_n;
  logic              srclk;
  logic              busy;
  logic [Width-1:0]  data_out;
  logic              data_valid;

  sync_2ff u_sync (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .d     (bus.ser_in),
    .q     (ser_sync)
  );

  // All chain-facing outputs are set alongside the state they belong to, so
  // each one comes straight from a flop and changes on the state boundary.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt_load   <= '0;
      cnt_div    <= '0;
      cnt_bit    <= '0;
      shreg      <= '0;
      sh_ld_n    <= 1'b1;
      srclk      <= 1'b0;
      busy       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.read_en) begin
            state    <= LOAD;
            sh_ld_n  <= 1'b0;
            busy     <= 1'b1;
            cnt_load <= '0;
          end
        end
        LOAD: begin
          if (cnt_load == LoadLast) begin
            state    <= SHIFT;
            sh_ld_n  <= 1'b1;
            cnt_load <= '0;
            cnt_div  <= '0;
            cnt_bit  <= '0;
          end else begin
            cnt_load <= cnt_load + 1'b1;
          end
        end
        SHIFT: begin
          // Sample just before srclk rises, a full period after QH last moved.
          if (cnt_div == DivSample) begin
            shreg <= {shreg[Width-2:0], ser_sync};
          end
          if (cnt_div == DivLast) begin
            cnt_div <= '0;
            srclk   <= 1'b0;
            if (cnt_bit == BitLast) begin
              state      <= DONE;
              cnt_bit    <= '0;
              data_out   <= shreg;
              data_valid <= 1'b1;
            end else begin
              cnt_bit <= cnt_bit + 1'b1;
            end
          end else begin
            cnt_div <= cnt_div + 1'b1;
            srclk   <= (cnt_div >= DivSample);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          sh_ld_n <= 1'b1;
          srclk   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sh_ld_n    = sh_ld_n;
  assign bus.srclk      = srclk;
  assign bus.clk_inh    = 1'b0;
  assign bus.busy       = busy;
  assign bus.data_out   = data_out;
  assign bus.data_valid = data_valid;

endmodule

// File: tb/tb_drive_74hc165.sv
// Directed bench for drive_74hc165 with behavioural '165 chain models for a
// 16-bit/div-10 instance and an 8-bit/div-4 instance.
module tb_drive_74hc165;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b1;

  always #5 sys_clk = ~sys_clk;

  drive_74hc165_if #(.Width(16)) bus16 ();
  drive_74hc165_if #(.Width(8))  bus8 ();

  drive_74hc165 #(.Width(16), .CLK_DIV(10)) dut16 (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus16)
  );

  drive_74hc165 #(.Width(8), .CLK_DIV(4)) dut8 (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus8)
  );

  // Chain models: parallel load while SH/LD is low, shift toward QH on CLK.
  logic [15:0] chain16 = '0;
  logic [15:0] pattern16 = '0;
  logic [7:0]  chain8 = '0;
  logic [7:0]  pattern8 = '0;

  always @(posedge bus16.srclk or negedge bus16.sh_ld_n) begin
    if (!bus16.sh_ld_n) chain16 <= pattern16;
    else                chain16 <= {chain16[14:0], 1'b0};
  end
  assign bus16.ser_in = chain16[15];

  always @(posedge bus8.srclk or negedge bus8.sh_ld_n) begin
    if (!bus8.sh_ld_n) chain8 <= pattern8;
    else               chain8 <= {chain8[6:0], 1'b0};
  end
  assign bus8.ser_in = chain8[7];

  int checks = 0;
  int passed = 0;

  int          dones[$];
  logic [15:0] words[$];
  logic [15:0] pat_next[$];
  int          rises, ld_falls, ld_first, ld_last;
  bit          busy_gap;

  // Returns just after edge 0, the edge that samples read_en high.
  task automatic start16(input bit held);
    @(negedge sys_clk);
    bus16.read_en = 1'b1;
    @(posedge sys_clk);
    #1;
    if (!held) bus16.read_en = 1'b0;
  endtask

  // Watches cycles 1..max_cyc, recording DONE cycles, words and pin activity.
  task automatic observe16(input int max_cyc, input int pulse_at, input int stop_after);
    logic prev_clk, prev_ld;
    dones.delete();
    words.delete();
    rises = 0; ld_falls = 0; ld_first = 0; ld_last = 0; busy_gap = 1'b0;
    prev_clk = bus16.srclk;
    prev_ld  = 1'b1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge sys_clk);
      if (pulse_at > 0 && k == pulse_at)     bus16.read_en = 1'b1;
      if (pulse_at > 0 && k == pulse_at + 1) bus16.read_en = 1'b0;
      if (bus16.srclk && !prev_clk) rises++;
      if (!bus16.sh_ld_n && prev_ld) begin
        ld_falls++;
        if (ld_falls == 1) ld_first = k;
      end
      if (!bus16.sh_ld_n && ld_falls == 1) ld_last = k;
      if (dones.size() == 0 && !bus16.busy) busy_gap = 1'b1;
      if (bus16.data_valid) begin
        dones.push_back(k);
        words.push_back(bus16.data_out);
        if (pat_next.size() > 0) pattern16 = pat_next.pop_front();
        if (dones.size() == stop_after) bus16.read_en = 1'b0;
      end
      prev_clk = bus16.srclk;
      prev_ld  = bus16.sh_ld_n;
    end
  endtask

  task automatic test_reset();
    bus16.read_en = 1'b0;
    bus8.read_en  = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    checks++; if (bus16.sh_ld_n !== 1'b1) $display("[TB] FAIL reset_sh_ld_n: got %b expected 1", bus16.sh_ld_n); else passed++;
    checks++; if (bus16.srclk !== 1'b0) $display("[TB] FAIL reset_srclk: got %b expected 0", bus16.srclk); else passed++;
    checks++; if (bus16.clk_inh !== 1'b0) $display("[TB] FAIL reset_clk_inh: got %b expected 0", bus16.clk_inh); else passed++;
    checks++; if (bus16.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus16.busy); else passed++;
    checks++; if (bus16.data_out !== 16'h0000) $display("[TB] FAIL reset_data_out: got %h expected 0000", bus16.data_out); else passed++;
    checks++; if (bus16.data_valid !== 1'b0) $display("[TB] FAIL reset_data_valid: got %b expected 0", bus16.data_valid); else passed++;
    checks++; if (bus8.sh_ld_n !== 1'b1) $display("[TB] FAIL reset8_sh_ld_n: got %b expected 1", bus8.sh_ld_n); else passed++;
    @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_single_frame();
    logic [15:0] w;
    int d;
    pattern16 = 16'hA5C3;
    start16(1'b0);
    observe16(172, 0, 0);
    w = (words.size() > 0) ? words[0] : 16'hxxxx;
    d = (dones.size() > 0) ? dones[0] : -1;
    checks++; if (dones.size() !== 1) $display("[TB] FAIL single_valid_count: got %0d expected 1", dones.size()); else passed++;
    checks++; if (d !== 165) $display("[TB] FAIL single_done_cycle: got %0d expected 165", d); else passed++;
    checks++; if (w !== 16'hA5C3) $display("[TB] FAIL single_word: got %h expected a5c3", w); else passed++;
    checks++; if (rises !== 16) $display("[TB] FAIL single_srclk_rises: got %0d expected 16", rises); else passed++;
    checks++; if (ld_first !== 1) $display("[TB] FAIL single_load_first: got %0d expected 1", ld_first); else passed++;
    checks++; if (ld_last !== 4) $display("[TB] FAIL single_load_last: got %0d expected 4", ld_last); else passed++;
    checks++; if (ld_falls !== 1) $display("[TB] FAIL single_load_count: got %0d expected 1", ld_falls); else passed++;
    checks++; if (bus16.data_out !== 16'hA5C3) $display("[TB] FAIL single_hold: got %h expected a5c3", bus16.data_out); else passed++;
  endtask

  task automatic test_ignore_pulse();
    logic [15:0] w;
    pattern16 = 16'h1234;
    start16(1'b0);
    observe16(172, 50, 0);
    w = (words.size() > 0) ? words[0] : 16'hxxxx;
    checks++; if (dones.size() !== 1) $display("[TB] FAIL pulse_valid_count: got %0d expected 1", dones.size()); else passed++;
    checks++; if (busy_gap !== 1'b0) $display("[TB] FAIL pulse_busy_gap: got %b expected 0", busy_gap); else passed++;
    checks++; if (ld_falls !== 1) $display("[TB] FAIL pulse_load_count: got %0d expected 1", ld_falls); else passed++;
    checks++; if (w !== 16'h1234) $display("[TB] FAIL pulse_word: got %h expected 1234", w); else passed++;
  endtask

  task automatic test_back_to_back();
    int d0, d1;
    logic [15:0] w0, w1;
    pattern16 = 16'h0001;
    pat_next.delete();
    pat_next.push_back(16'h8000);
    start16(1'b1);
    observe16(340, 0, 2);
    bus16.read_en = 1'b0;
    d0 = (dones.size() > 0) ? dones[0] : -1;
    d1 = (dones.size() > 1) ? dones[1] : -1;
    w0 = (words.size() > 0) ? words[0] : 16'hxxxx;
    w1 = (words.size() > 1) ? words[1] : 16'hxxxx;
    checks++; if (dones.size() !== 2) $display("[TB] FAIL b2b_valid_count: got %0d expected 2", dones.size()); else passed++;
    checks++; if (d0 !== 165) $display("[TB] FAIL b2b_first_done: got %0d expected 165", d0); else passed++;
    checks++; if (d1 - d0 !== 166) $display("[TB] FAIL b2b_period: got %0d expected 166", d1 - d0); else passed++;
    checks++; if (w0 !== 16'h0001) $display("[TB] FAIL b2b_word0: got %h expected 0001", w0); else passed++;
    checks++; if (w1 !== 16'h8000) $display("[TB] FAIL b2b_word1: got %h expected 8000", w1); else passed++;
    checks++; if (ld_falls !== 2) $display("[TB] FAIL b2b_load_count: got %0d expected 2", ld_falls); else passed++;
  endtask

  task automatic test_mid_reset();
    logic [15:0] w;
    int d;
    bit seen_valid;
    pattern16 = 16'h5A5A;
    seen_valid = 1'b0;
    start16(1'b0);
    for (int k = 1; k <= 80; k++) begin
      @(negedge sys_clk);
      if (bus16.data_valid) seen_valid = 1'b1;
    end
    checks++; if (bus16.srclk !== 1'b1) $display("[TB] FAIL midrst_srclk_before: got %b expected 1", bus16.srclk); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (bus16.srclk !== 1'b0) $display("[TB] FAIL midrst_srclk: got %b expected 0", bus16.srclk); else passed++;
    checks++; if (bus16.sh_ld_n !== 1'b1) $display("[TB] FAIL midrst_sh_ld_n: got %b expected 1", bus16.sh_ld_n); else passed++;
    checks++; if (bus16.busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b expected 0", bus16.busy); else passed++;
    checks++; if (bus16.data_out !== 16'h0000) $display("[TB] FAIL midrst_data_out: got %h expected 0000", bus16.data_out); else passed++;
    repeat (3) begin
      @(negedge sys_clk);
      if (bus16.data_valid) seen_valid = 1'b1;
    end
    checks++; if (seen_valid !== 1'b0) $display("[TB] FAIL midrst_no_valid: got %b expected 0", seen_valid); else passed++;
    rst_n = 1'b1;
    pattern16 = 16'h3C96;
    start16(1'b0);
    observe16(172, 0, 0);
    w = (words.size() > 0) ? words[0] : 16'hxxxx;
    d = (dones.size() > 0) ? dones[0] : -1;
    checks++; if (w !== 16'h3C96) $display("[TB] FAIL midrst_recover_word: got %h expected 3c96", w); else passed++;
    checks++; if (d !== 165) $display("[TB] FAIL midrst_recover_done: got %0d expected 165", d); else passed++;
  endtask

  task automatic test_ones_zeros();
    logic [15:0] w;
    pattern16 = 16'hFFFF;
    start16(1'b0);
    observe16(172, 0, 0);
    w = (words.size() > 0) ? words[0] : 16'hxxxx;
    checks++; if (w !== 16'hFFFF) $display("[TB] FAIL ones_word: got %h expected ffff", w); else passed++;
    pattern16 = 16'h0000;
    start16(1'b0);
    observe16(172, 0, 0);
    w = (words.size() > 0) ? words[0] : 16'hxxxx;
    checks++; if (w !== 16'h0000) $display("[TB] FAIL zeros_word: got %h expected 0000", w); else passed++;
  endtask

  task automatic test_width8();
    int done8, valids, rises8;
    logic [7:0] word8;
    logic prev_clk;
    done8 = -1; valids = 0; rises8 = 0; word8 = 8'hxx;
    pattern8 = 8'h5A;
    @(negedge sys_clk);
    bus8.read_en = 1'b1;
    @(posedge sys_clk);
    #1;
    bus8.read_en = 1'b0;
    prev_clk = bus8.srclk;
    for (int k = 1; k <= 45; k++) begin
      @(negedge sys_clk);
      if (bus8.srclk && !prev_clk) rises8++;
      if (bus8.data_valid) begin
        valids++;
        if (done8 < 0) begin
          done8 = k;
          word8 = bus8.data_out;
        end
      end
      prev_clk = bus8.srclk;
    end
    checks++; if (valids !== 1) $display("[TB] FAIL w8_valid_count: got %0d expected 1", valids); else passed++;
    checks++; if (done8 !== 37) $display("[TB] FAIL w8_done_cycle: got %0d expected 37", done8); else passed++;
    checks++; if (word8 !== 8'h5A) $display("[TB] FAIL w8_word: got %h expected 5a", word8); else passed++;
    checks++; if (rises8 !== 8) $display("[TB] FAIL w8_srclk_rises: got %0d expected 8", rises8); else passed++;
  endtask

  initial begin
    $display("[TB] starting drive_74hc165 bench");
    test_reset();
    test_single_frame();
    test_ignore_pulse();
    test_back_to_back();
    test_mid_reset();
    test_ones_zeros();
    test_width8();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
